// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment encodings,
// the nibble-to-segment mapping and a constant-friendly clog2.
package seg7_pkg;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;  // lower-case b
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;  // lower-case d
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Lookup table indexed by the nibble value; entry 15 is leftmost.
    localparam logic [15:0][6:0] SEG_HEX = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    // Active-high segment pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

    // Ceiling log2, never below 1 so that index vectors always have a bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder with a blanking override.
// Output is active-high; pin polarity is applied by the caller.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the nibble value.
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment scanner. A prescaler divides sys_clk
// into digit slots; each slot starts with a dark guard interval to stop
// ghosting between digits. Display data is captured once per frame into a
// shadow register so a frame never mixes old and new values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter int BLINK_LOG2     = 24,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                             sys_clk,
    input  logic                             scan_rst,
    input  logic [4*NUM_DIGITS-1:0]          data,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic [NUM_DIGITS-1:0]            blank_mask,
    input  logic [NUM_DIGITS-1:0]            blink_en,
    input  logic                             lz_blank,
    input  logic                             freeze,
    output logic [6:0]                       Y_r,
    output logic                             dp_r,
    output logic [NUM_DIGITS-1:0]            DIG_r,
    output logic [clog2(NUM_DIGITS)-1:0]     scan_idx
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PC_W  = clog2(SCAN_DIV);

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0]  PC_GUARD = PC_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Pin levels that mean "off" after polarity is applied.
    localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_LOG2-1:0] bc_q;

    logic tick;
    logic frame_start;
    logic lit;
    logic blink_phase;

    assign tick        = (pc_q == PC_LAST);
    assign frame_start = (pc_q == '0) && (idx_q == '0);
    assign lit         = (pc_q >= PC_GUARD);
    assign blink_phase = bc_q[BLINK_LOG2-1];

    // Next prescaler value and slot index; the index only moves on a tick.
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        pc_d  = tick ? '0 : pc_q + PC_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Prescaler, slot index and free-running blink counter.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (scan_rst) begin
            pc_q  <= '0;
            idx_q <= '0;
            bc_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            idx_q <= idx_d;
            bc_q  <= bc_q + BLINK_LOG2'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot
    // ------------------------------------------------------------------
    logic                    first_q;
    logic [4*NUM_DIGITS-1:0] sh_data_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q;
    logic [NUM_DIGITS-1:0]   sh_blink_q;
    logic                    sh_lz_q;
    logic                    snap_load;

    // The first cycle out of reset always captures, even under freeze, so the
    // display never shows the all-zero reset shadow for a whole frame.
    assign snap_load = first_q || (frame_start && !freeze);

    // Shadow capture at frame start; held while frozen.
    // NOTE: the shadow is a handful of flops, not a RAM, so it is cleared on reset like any other register.
    always_ff @(posedge sys_clk) begin
        if (scan_rst) begin
            first_q    <= 1'b1;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_blink_q <= '0;
            sh_lz_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if (snap_load) begin
                sh_data_q  <= data;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank_mask;
                sh_blink_q <= blink_en;
                sh_lz_q    <= lz_blank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit blanking
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_vec;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_from_top;

    // Leading-zero suppression walks down from the most significant digit;
    // digit 0 is never suppressed so a zero value still shows "0".
    always_comb begin
        lz_vec        = '0;
        zero_from_top = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_from_top = zero_from_top && (sh_data_q[4*i +: 4] == 4'h0);
            lz_vec[i]     = sh_lz_q && zero_from_top;
        end
        blank_vec = sh_blank_q
                  | (sh_blink_q & {NUM_DIGITS{blink_phase}})
                  | lz_vec;
    end

    // ------------------------------------------------------------------
    // Digit mux and decode
    // ------------------------------------------------------------------
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [6:0]            seg_raw;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] dig_onehot;

    assign cur_nibble = sh_data_q[{idx_q, 2'b00} +: 4];
    assign cur_blank  = blank_vec[idx_q];
    assign cur_dp     = sh_dp_q[idx_q];
    assign dp_on      = lit && !cur_blank && cur_dp;

    // Segments are also dark during the guard interval.
    seg7_hex_decoder u_decoder (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank || !lit),
        .seg_o    (seg_raw)
    );

    // One-hot digit enable for the current slot, none during the guard.
    always_comb begin
        dig_onehot = '0;
        if (lit) begin
            dig_onehot[idx_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered pin drivers
    // ------------------------------------------------------------------
    // Apply polarity and register everything so the pins change together.
    always_ff @(posedge sys_clk) begin
        if (scan_rst) begin
            Y_r      <= SEG_OFF;
            dp_r     <= DP_OFF;
            DIG_r    <= DIG_OFF;
            scan_idx <= '0;
        end else begin
            Y_r      <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dp_r     <= dp_on ^ SEG_ACTIVE_LOW;
            DIG_r    <= dig_onehot ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
            scan_idx <= idx_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver. Three instances cover the 4-digit
// scan/lz/tearing/freeze/reset cases, blink with a short blink counter,
// and the 8-digit wrap. Expected pin values come from hand-computed
// active-low segment tables and a slot/phase count since reset release.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int t_cur    = 0;

    // ---------------- instance 0: 4 digits, SCAN_DIV 8, GUARD 2 ----------
    logic        rst4;
    logic [15:0] data4;
    logic [3:0]  dp4, blank4, blinken4;
    logic        lz4, frz4;
    logic [6:0]  y4;
    logic        dpo4;
    logic [3:0]  dig4;
    logic [1:0]  idx4;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BLINK_LOG2(24),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u4 (
        .sys_clk(clk), .scan_rst(rst4), .data(data4), .dp_in(dp4),
        .blank_mask(blank4), .blink_en(blinken4), .lz_blank(lz4),
        .freeze(frz4), .Y_r(y4), .dp_r(dpo4), .DIG_r(dig4), .scan_idx(idx4)
    );

    // ---------------- instance 1: blink, SCAN_DIV 6, BLINK_LOG2 4 --------
    logic        rstb;
    logic [15:0] datab;
    logic [3:0]  blinkb;
    logic [6:0]  yb;
    logic        dpob;
    logic [3:0]  digb;
    logic [1:0]  idxb;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(6), .GUARD(2), .BLINK_LOG2(4),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) ub (
        .sys_clk(clk), .scan_rst(rstb), .data(datab), .dp_in(4'b0000),
        .blank_mask(4'b0000), .blink_en(blinkb), .lz_blank(1'b0),
        .freeze(1'b0), .Y_r(yb), .dp_r(dpob), .DIG_r(digb), .scan_idx(idxb)
    );

    // ---------------- instance 2: 8 digits, SCAN_DIV 4, GUARD 1 ----------
    logic        rst8;
    logic [31:0] data8;
    logic [7:0]  dp8;
    logic [6:0]  y8;
    logic        dpo8;
    logic [7:0]  dig8;
    logic [2:0]  idx8;

    seg7_scan_driver #(
        .NUM_DIGITS(8), .SCAN_DIV(4), .GUARD(1), .BLINK_LOG2(24),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u8 (
        .sys_clk(clk), .scan_rst(rst8), .data(data8), .dp_in(dp8),
        .blank_mask(8'h00), .blink_en(8'h00), .lz_blank(1'b0),
        .freeze(1'b0), .Y_r(y8), .dp_r(dpo8), .DIG_r(dig8), .scan_idx(idx8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pack four per-digit active-low patterns (digit 3 first).
    function automatic logic [7:0][6:0] ey4(input logic [6:0] d3, input logic [6:0] d2,
                                             input logic [6:0] d1, input logic [6:0] d0);
        logic [7:0][6:0] r;
        r    = '0;
        r[3] = d3;
        r[2] = d2;
        r[1] = d1;
        r[0] = d0;
        return r;
    endfunction

    // Read back one instance's pins, padded to common widths.
    task automatic sample(input int inst, output logic [7:0] dig_o, output logic [6:0] y_o,
                          output logic dp_o, output logic [2:0] idx_o);
        case (inst)
            0:       begin dig_o = {4'hF, dig4}; y_o = y4; dp_o = dpo4; idx_o = {1'b0, idx4}; end
            1:       begin dig_o = {4'hF, digb}; y_o = yb; dp_o = dpob; idx_o = {1'b0, idxb}; end
            default: begin dig_o = dig8;         y_o = y8; dp_o = dpo8; idx_o = idx8;         end
        endcase
    endtask

    // Pulse reset for one edge and check every pin goes inactive.
    task automatic do_reset(input string tag, input int inst);
        logic [7:0] dig_o;
        logic [6:0] y_o;
        logic       dp_o;
        logic [2:0] idx_o;
        case (inst)
            0:       rst4 = 1'b1;
            1:       rstb = 1'b1;
            default: rst8 = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        sample(inst, dig_o, y_o, dp_o, idx_o);
        check({tag, " rst dig"}, dig_o, 8'hFF);
        check({tag, " rst y"},   y_o,   7'h7F);
        check({tag, " rst dp"},  dp_o,  1'b1);
        check({tag, " rst idx"}, idx_o, 3'd0);
        case (inst)
            0:       rst4 = 1'b0;
            1:       rstb = 1'b0;
            default: rst8 = 1'b0;
        endcase
        t_cur = 0;
    endtask

    // Run ncyc cycles, checking each one against the slot/phase position.
    // t_cur is the prescaler count the pins reflect after this edge.
    task automatic run(input string tag, input int inst, input int ncyc,
                       input logic [7:0][6:0] ey, input logic [7:0] edp);
        for (int c = 0; c < ncyc; c++) begin
            int         sd, g, n, slot, ph;
            logic       blink;
            logic [7:0] dig_o, dig_e;
            logic [6:0] y_o, y_e;
            logic       dp_o, dp_e;
            logic [2:0] idx_o, idx_e;
            @(posedge clk);
            @(negedge clk);
            sample(inst, dig_o, y_o, dp_o, idx_o);
            case (inst)
                0:       begin sd = 8; g = 2; n = 4; blink = 1'b0; end
                1:       begin sd = 6; g = 2; n = 4; blink = t_cur[3]; end
                default: begin sd = 4; g = 1; n = 8; blink = 1'b0; end
            endcase
            slot  = (t_cur / sd) % n;
            ph    = t_cur % sd;
            idx_e = 3'(slot);
            dig_e = 8'hFF;
            y_e   = 7'h7F;
            dp_e  = 1'b1;
            if (ph >= g) begin
                dig_e[slot] = 1'b0;
                y_e         = (blink && slot == 0) ? 7'h7F : ey[slot];
                dp_e        = ~edp[slot];
            end
            check($sformatf("%s dig t=%0d", tag, t_cur), dig_o, dig_e);
            check($sformatf("%s y t=%0d",   tag, t_cur), y_o,   y_e);
            check($sformatf("%s dp t=%0d",  tag, t_cur), dp_o,  dp_e);
            check($sformatf("%s idx t=%0d", tag, t_cur), idx_o, idx_e);
            t_cur++;
        end
    endtask

    initial begin
        rst4 = 1'b1; rstb = 1'b1; rst8 = 1'b1;
        data4 = 16'h12AF; dp4 = 4'h0; blank4 = 4'h0; blinken4 = 4'h0;
        lz4 = 1'b0; frz4 = 1'b0;
        datab = 16'h12AF; blinkb = 4'b0001;
        data8 = 32'h7654_3210; dp8 = 8'h80;
        repeat (2) @(negedge clk);

        // Basic scan of 12AF over two frames.
        do_reset("scan", 0);
        run("scan", 0, 64, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);

        // Decimal point on digit 0 only.
        dp4 = 4'b0001;
        run("dp", 0, 32, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h01);
        dp4 = 4'b0000;

        // Forced blank of digit 2.
        blank4 = 4'b0100;
        run("blank", 0, 32, ey4(7'h79, 7'h7F, 7'h08, 7'h0E), 8'h00);
        blank4 = 4'b0000;

        // Leading-zero suppression.
        lz4 = 1'b1; data4 = 16'h0030;
        run("lz0030", 0, 32, ey4(7'h7F, 7'h7F, 7'h30, 7'h40), 8'h00);
        data4 = 16'h0000;
        run("lz0000", 0, 32, ey4(7'h7F, 7'h7F, 7'h7F, 7'h40), 8'h00);
        data4 = 16'h1005;
        run("lz1005", 0, 32, ey4(7'h79, 7'h40, 7'h40, 7'h12), 8'h00);
        lz4 = 1'b0;

        // Tearing: data changes while slot 2 is lit.
        data4 = 16'h12AF;
        do_reset("tear", 0);
        run("tear_pre", 0, 20, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);
        data4 = 16'h3456;
        run("tear_old", 0, 12, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);
        run("tear_new", 0, 32, ey4(7'h30, 7'h19, 7'h12, 7'h02), 8'h00);

        // Freeze holds the snapshot for three frames, then releases.
        frz4 = 1'b1; data4 = 16'hABCD;
        run("frozen", 0, 96, ey4(7'h30, 7'h19, 7'h12, 7'h02), 8'h00);
        frz4 = 1'b0;
        run("thaw", 0, 32, ey4(7'h08, 7'h03, 7'h46, 7'h21), 8'h00);

        // Reset mid-frame while digit 2 is lit, then relight from digit 0.
        data4 = 16'h12AF;
        run("pre_rst", 0, 20, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);
        do_reset("mid", 0);
        run("post_rst", 0, 32, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);

        // First cycle after reset captures even while frozen.
        frz4 = 1'b1; data4 = 16'h0F0F;
        do_reset("frzrst", 0);
        run("frzrst", 0, 32, ey4(7'h40, 7'h0E, 7'h40, 7'h0E), 8'h00);
        frz4 = 1'b0;

        // Blink on digit 0 with a 4-bit blink counter.
        do_reset("blink", 1);
        run("blink", 1, 96, ey4(7'h79, 7'h24, 7'h08, 7'h0E), 8'h00);

        // Eight-digit wrap with the decimal point in slot 7.
        do_reset("wrap8", 2);
        run("wrap8", 2, 64,
            {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the board top level (`cpu_board_final`). It replaces the fixed 4-digit scan logic behind `Y_r`/`DIG_r` with a generic N-digit scanner. It adds:
- frame-coherent data snapshots (no tearing)
- anti-ghosting guard intervals
- leading-zero suppression
- per-digit blanking, blink and decimal-point control

CPU-side debug values (register file, PC, data memory) arrive on `data` as packed hex nibbles.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits, 2..8.
- `SCAN_DIV`, 50000: `sys_clk` cycles per digit slot, >= 4.
- `GUARD`, 2: cycles at slot start with all digits off. Must satisfy 1 <= `GUARD` < `SCAN_DIV`.
- `BLINK_LOG2`, 24: width of the blink counter. Its MSB is the blink phase.
- `SEG_ACTIVE_LOW`, 1: 1 means segments/dp are driven low-on.
- `DIG_ACTIVE_LOW`, 1: 1 means digit enables are driven low-on.

Ports:
- `sys_clk`  in  1  system clock.
- `scan_rst`  in  1  reset, synchronous, active-high.
- `data`  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i, and digit 0 is the rightmost.
- `dp_in`  in  NUM_DIGITS  decimal point per digit.
- `blank_mask`  in  NUM_DIGITS  1 forces the digit blank.
- `blink_en`  in  NUM_DIGITS  1 blanks the digit during the blink phase.
- `lz_blank`  in  1  enables leading-zero suppression.
- `freeze`  in  1  holds the current snapshot.
- `Y_r`  out  7  segments {g,f,e,d,c,b,a}, registered.
- `dp_r`  out  1  decimal point, registered.
- `DIG_r`  out  NUM_DIGITS  digit enables, registered.
- `scan_idx`  out  clog2(NUM_DIGITS)  current slot index, registered.

## Operation
Counters:
- Prescaler `pc` counts 0..SCAN_DIV-1 and wraps. The slot tick occurs at `pc==SCAN_DIV-1`.
- `scan_idx` increments on each tick and wraps from NUM_DIGITS-1 to 0.
- Blink counter `bc` (BLINK_LOG2 bits) is free-running. The blink phase is `bc[BLINK_LOG2-1]==1`.

Snapshot:
- The shadow register loads `data`, `dp_in`, `blank_mask`, `blink_en` and `lz_blank` when `pc==0 && scan_idx==0 && !freeze`.
- This load also happens on the first cycle after reset.
- Inputs that change mid-frame have no effect until the next frame start.
- While `freeze=1` the shadow holds indefinitely.

Digit i is blank when any of the following holds:
- shadow `blank_mask[i]` is set;
- shadow `blink_en[i]` is set and the blink phase is active;
- leading-zero rule: shadow `lz_blank`, i>0, and nibbles i..NUM_DIGITS-1 are all 0 (digit 0 is never suppressed by this rule).

Segment pattern (active-high, before polarity):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blank gives 00 and dp off.
- Output polarity is applied by XOR with the `SEG_ACTIVE_LOW` / `DIG_ACTIVE_LOW` parameters.

Digit enable:
- Exactly one digit (the one at `scan_idx`) is enabled when `pc>=GUARD`.
- No digit is enabled when `pc<GUARD`.
- At most one digit is ever enabled.

## Timing
- All outputs are registered, with a 1-cycle latency from `pc`/`scan_idx`/shadow to the pins.
- Reset values:
  - `pc=0`, `scan_idx=0`, `bc=0`, shadow=0.
  - `Y_r` inactive (7'h7F when active-low), `dp_r` inactive, `DIG_r` all inactive.
- After reset release, cycle 0 loads the shadow. `DIG_r[0]` first goes active on the output at cycle GUARD+1.
- Per slot: GUARD cycles dark, then SCAN_DIV-GUARD cycles lit.
- Frame length is NUM_DIGITS*SCAN_DIV cycles.
- Reset mid-slot: on the cycle after `scan_rst` is sampled high, all outputs are inactive and `scan_idx=0`. Reset has priority over tick, snapshot and freeze.
- A tick coinciding with a frame wrap updates `scan_idx` to 0. The snapshot loads on the following cycle (`pc==0`).
- The blink phase is sampled combinationally per cycle, so blink transitions may occur mid-slot.

## Structure
- Package `seg7_pkg` holds:
  - segment encoding constants (`SEG_BLANK`, hex patterns);
  - function `hex_to_seg`;
  - the `clog2` helper.
- Sub-module `seg7_hex_decoder` (combinational nibble → 7 bits), instantiated once on the muxed nibble.
- Prescaler, index, snapshot and blink logic live in the top module.

## Test plan
1. Basic scan. Setup: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, `data`=16'h12AF, active-low. Required response:
   - `DIG_r` cycles 1110, 1101, 1011, 0111; each is lit 6 cycles, preceded by 2 cycles of 1111.
   - `Y_r` is 0E, 08, 24, 79 respectively.
2. Leading-zero suppression. Setup: `lz_blank=1`. Required response:
   - `data`=16'h0030: digits 3 and 2 show `Y_r`=7F, digit 1 shows 30, digit 0 shows 40.
   - `data`=0: only digit 0 shows 40.
3. Tearing and freeze:
   - Changing `data` while `scan_idx=2` → digits 2 and 3 keep the old values until the next frame.
   - With `freeze=1`, the old values persist for 3 frames.
4. Blink. Setup: BLINK_LOG2=4, `blink_en`=0001. Required response: `Y_r`=7F during digit 0 whenever `bc[3]=1`; other digits are unaffected.
5. Reset mid-frame. Stimulus: assert `scan_rst` for 1 cycle while digit 2 is lit. Required response:
   - Next cycle: `DIG_r`=1111, `Y_r`=7F, `scan_idx`=0.
   - Relight of digit 0 at GUARD+1 after release.
6. Eight-digit wrap. Setup: NUM_DIGITS=8, `dp_in`=8'h80. Required response:
   - One-hot `DIG_r` walks 8 positions and `scan_idx` wraps 7→0.
   - `dp_r` is active only in slot 7.
